// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline constants for hazard control
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO           = 5'd0;
    localparam int         MD_LATENCY_DEFAULT = 4;

endpackage

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush control: load-use interlock, branch flush, mult/div freeze
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int CNT_W      = 4,
    parameter int STALL_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         ID_regRs,
    input  logic [4:0]         ID_regRt,
    input  logic               ID_usesRt,
    input  logic [4:0]         ID_EX_regRt,
    input  logic               ID_EX_memRead,
    input  logic               branch_taken,
    input  logic               md_start,
    output logic               PC_write,
    output logic               IF_ID_write,
    output logic               IF_ID_flush,
    output logic               ID_EX_write,
    output logic               ID_EX_flush,
    output logic               EX_MEM_flush,
    output logic               md_busy,
    output logic               md_done,
    output logic [STALL_W-1:0] stall_cycles
);

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               load_use;

    // $0 is hard-wired, so a load targeting it can never feed a consumer
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
    endfunction

    assign load_use = load_use_hit(ID_EX_memRead, ID_EX_regRt, ID_regRs, ID_regRt, ID_usesRt);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_write  = 1'b1;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                end else if (load_use) begin
                    PC_write    = 1'b0;
                    IF_ID_write = 1'b0;
                    ID_EX_flush = 1'b1;
                end
                if (md_start) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_W'(MD_LATENCY - 1);
                end
            end
            MD_BUSY: begin
                PC_write     = 1'b0;
                IF_ID_write  = 1'b0;
                ID_EX_write  = 1'b0;
                EX_MEM_flush = 1'b1;
                md_busy      = 1'b1;
                if (cnt_q == '0) begin
                    md_done = 1'b1;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (!PC_write && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

    // The branch unit must never resolve a taken branch while EX is frozen
    always @(posedge clk) begin
        if (!rst && state_q == MD_BUSY) begin
            assert (!branch_taken);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int SW = 4;

    // Expected control vector order: pc, ifid_w, ifid_f, idex_w, idex_f, exmem_f, busy, done
    localparam logic [7:0] NORM = 8'b1_1_0_1_0_0_0_0;
    localparam logic [7:0] LU   = 8'b0_0_0_1_1_0_0_0;
    localparam logic [7:0] BR   = 8'b1_1_1_1_1_0_0_0;
    localparam logic [7:0] BUSY = 8'b0_0_0_0_0_1_1_0;
    localparam logic [7:0] DONE = 8'b0_0_0_0_0_1_1_1;

    typedef struct packed {
        logic [7:0]    ctl;
        logic [SW-1:0] stall;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    ID_regRs, ID_regRt, ID_EX_regRt;
    logic          ID_usesRt, ID_EX_memRead, branch_taken, md_start;
    logic          PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush;
    logic          EX_MEM_flush, md_busy, md_done;
    logic [SW-1:0] stall_cycles;

    exp_t          sb_q[$];
    int            checks   = 0;
    int            failures = 0;
    int            exp_stall = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4), .STALL_W(SW)) dut (
        .clk(clk), .rst(rst),
        .ID_regRs(ID_regRs), .ID_regRt(ID_regRt), .ID_usesRt(ID_usesRt),
        .ID_EX_regRt(ID_EX_regRt), .ID_EX_memRead(ID_EX_memRead),
        .branch_taken(branch_taken), .md_start(md_start),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_write(ID_EX_write), .ID_EX_flush(ID_EX_flush),
        .EX_MEM_flush(EX_MEM_flush), .md_busy(md_busy), .md_done(md_done),
        .stall_cycles(stall_cycles)
    );

    function automatic logic [7:0] obs_ctl();
        return {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write,
                ID_EX_flush, EX_MEM_flush, md_busy, md_done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push the expectation, compare at the falling edge,
    // then advance the reference stall count across the rising edge.
    task automatic cycle(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                         input logic uses, input logic [4:0] exrt, input logic mr,
                         input logic br, input logic mds, input logic [7:0] e);
        exp_t got;
        ID_regRs = rs; ID_regRt = rt; ID_usesRt = uses;
        ID_EX_regRt = exrt; ID_EX_memRead = mr; branch_taken = br; md_start = mds;
        sb_q.push_back('{ctl: e, stall: SW'(exp_stall)});
        @(negedge clk);
        got = sb_q.pop_front();
        check({tag, "_ctl"}, 32'(obs_ctl()), 32'(got.ctl));
        check({tag, "_stall"}, 32'(stall_cycles), 32'(got.stall));
        if (!got.ctl[7] && exp_stall < (1 << SW) - 1) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ID_regRs = '0; ID_regRt = '0; ID_usesRt = 1'b0;
        ID_EX_regRt = '0; ID_EX_memRead = 1'b0; branch_taken = 1'b0; md_start = 1'b0;
        @(negedge clk);
        check("reset_ctl", 32'(obs_ctl()), 32'(NORM));
        check("reset_stall", 32'(stall_cycles), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        cycle("idle",       5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM);
        cycle("lu_rs",      5'd8, 5'd3, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, LU);
        cycle("lu_rs_next", 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM);
        cycle("lu_rt",      5'd1, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, LU);
        cycle("zero_reg",   5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, NORM);
        cycle("rt_unused",  5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, NORM);
        cycle("no_load",    5'd8, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, NORM);
        cycle("br_over_lu", 5'd8, 5'd3, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, BR);

        // mult/div at t; load-use shows up mid-freeze and must wait for t+5
        cycle("md_t",       5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NORM);
        cycle("md_t1",      5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, BUSY);
        cycle("md_t2",      5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, BUSY);
        cycle("md_t3",      5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, BUSY);
        cycle("md_t4",      5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, DONE);
        cycle("md_t5_lu",   5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, LU);
        cycle("md_t6",      5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM);

        // taken branch together with md_start: flush now, freeze next
        cycle("brmd_t",     5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, BR);
        cycle("brmd_t1",    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, BUSY);
        cycle("brmd_t2",    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, BUSY);
        cycle("brmd_t3",    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, BUSY);
        cycle("brmd_t4",    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, DONE);
        cycle("brmd_t5",    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM);

        // asynchronous reset while the freeze counter sits at 2
        cycle("rmd_t",      5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NORM);
        cycle("rmd_t1",     5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, BUSY);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pc", 32'(PC_write), 32'd1);
        check("async_rst_busy", 32'(md_busy), 32'd0);
        check("async_rst_stall", 32'(stall_cycles), 32'd0);
        exp_stall = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        cycle("post_rst",   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM);

        for (int i = 0; i < 20; i++) begin
            cycle("sat_lu", 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, LU);
        end
        cycle("sat_hold",   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM);
        check("sat_value", 32'(stall_cycles), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
